reg_bank_arbiter: RTL and testbench

- Shares one register-bank access port between NUM_REQ requesters, e.g. the SPI slave and an on-chip debug/test master.
- Round-robin arbitration; one transaction in flight at a time.
- Latches the winner's command, drives the bank's application interface, captures rdata/err on ack, and returns a one-cycle done pulse to the winner.
- Sits between the requesters and the register bank.

---
 rtl/reg_bank_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register-bank port between NUM_REQ requesters.
// Optional ACCESS timeout is enabled by defining REG_BANK_ARB_TIMEOUT_EN.
module reg_bank_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 8,
    parameter int REG_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr_rdn,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*REG_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [REG_W-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      m_ena,
    output logic                      m_wr_rdn,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [REG_W-1:0]          m_wdata,
    output logic                      m_we,
    input  logic [REG_W-1:0]          m_rdata,
    input  logic                      m_ack,
    input  logic                      m_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               wr_rdn_q, wr_rdn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [REG_W-1:0]   wdata_q, wdata_d;
    logic [REG_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               found;
    logic [IDX_W-1:0]   pick;
    int                 arb_idx;
    logic [NUM_REQ-1:0] owner;

`ifdef REG_BANK_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        found   = 1'b0;
        pick    = last_grant_q;
        arb_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req[arb_idx]) begin
                found = 1'b1;
                pick  = IDX_W'(arb_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        wr_rdn_d     = wr_rdn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
`ifdef REG_BANK_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d    = pick;
                    wr_rdn_d = req_wr_rdn[pick];
                    addr_d   = req_addr[pick*ADDR_W +: ADDR_W];
                    wdata_d  = req_wdata[pick*REG_W +: REG_W];
                    state_d  = ACCESS;
`ifdef REG_BANK_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ACCESS: begin
                if (m_ack) begin
                    rsp_rdata_d = wr_rdn_q ? '0 : m_rdata;
                    rsp_err_d   = m_err;
                    state_d     = RESP;
                end
`ifdef REG_BANK_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                last_grant_d = win_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset abandons any transaction; last_grant starts at the top so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            win_q        <= '0;
            wr_rdn_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
`ifdef REG_BANK_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            wr_rdn_q     <= wr_rdn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
`ifdef REG_BANK_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign owner     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
    assign busy      = (state_q != IDLE);
    assign gnt       = busy ? owner : '0;
    assign done      = (state_q == RESP) ? owner : '0;
    assign m_ena     = (state_q == ACCESS);
    assign m_wr_rdn  = wr_rdn_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_we      = m_ena & wr_rdn_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: table-driven single transactions,
// round-robin, stalled-ack and reset-abort sequences, with a done scoreboard.
module tb_reg_bank_arbiter;

    bit          clk;
    logic        rstb;
    logic [1:0]  req;
    logic [1:0]  req_wr_rdn;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        m_ena;
    logic        m_wr_rdn;
    logic [7:0]  m_addr;
    logic [7:0]  m_wdata;
    logic        m_we;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_ack   = 1'b0;
    logic        m_err   = 1'b0;

    reg_bank_arbiter dut (
        .clk(clk), .rstb(rstb), .req(req), .req_wr_rdn(req_wr_rdn),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .m_ena(m_ena),
        .m_wr_rdn(m_wr_rdn), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         who;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
        bit         err;
        logic [1:0] exp_done;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [1:0] d;
        logic [7:0] rd;
        logic       e;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_delay = 0;
    bit   bank_err = 1'b0;
    int   acc_cnt = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc++;

    // Bank model: acks in ACCESS cycle ack_delay (never if negative); read data = addr ^ A6.
    always @(negedge clk) begin
        if (m_ena) begin
            m_ack   = (ack_delay >= 0) && (acc_cnt == ack_delay);
            m_err   = m_ack ? bank_err : 1'b0;
            m_rdata = m_addr ^ 8'hA6;
            acc_cnt++;
        end else begin
            m_ack   = 1'b0;
            m_err   = 1'b0;
            acc_cnt = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (mon_en && done !== 2'b00) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {30'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_done", {30'd0, done}, {30'd0, e.d});
                checkOutput("sb_rdata", {24'd0, rsp_rdata}, {24'd0, e.rd});
                checkOutput("sb_err", {31'd0, rsp_err}, {31'd0, e.e});
            end
        end
    end

    task automatic setRequester(input int who, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        req_wr_rdn[who]     = wr;
        req_addr[who*8 +: 8]  = addr;
        req_wdata[who*8 +: 8] = wdata;
    endtask

    task automatic pushExp(input logic [1:0] d, input logic [7:0] rd, input logic e);
        exp_t x;
        x.d = d; x.rd = rd; x.e = e;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        ack_delay = v.delay;
        bank_err  = v.err;
        setRequester(v.who, v.wr, v.addr, v.wdata);
        pushExp(v.exp_done, v.exp_rdata, v.exp_err);
        req[v.who] = 1'b1;
        @(negedge clk);
        checkOutput("gnt_access", {30'd0, gnt}, {30'd0, v.exp_done});
        checkOutput("m_ena_access", {31'd0, m_ena}, 32'd1);
        checkOutput("m_addr", {24'd0, m_addr}, {24'd0, v.addr});
        checkOutput("m_we", {31'd0, m_we}, {31'd0, v.wr});
        if (v.wr) checkOutput("m_wdata", {24'd0, m_wdata}, {24'd0, v.wdata});
        n = 0;
        while (done == 2'b00 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency", n, v.delay + 1);
        req[v.who] = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int last;
        vecs[0] = '{0, 1'b0, 8'h03, 8'h00, 0, 1'b0, 2'b01, 8'hA5, 1'b0};
        vecs[1] = '{1, 1'b1, 8'h07, 8'h5C, 0, 1'b0, 2'b10, 8'h00, 1'b0};
        vecs[2] = '{0, 1'b0, 8'h10, 8'h00, 4, 1'b1, 2'b01, 8'hB6, 1'b1};
        vecs[3] = '{1, 1'b0, 8'hFF, 8'h00, 2, 1'b0, 2'b10, 8'h59, 1'b0};
        vecs[4] = '{0, 1'b1, 8'h22, 8'h11, 1, 1'b1, 2'b01, 8'h00, 1'b1};
        vecs[5] = '{1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 2'b10, 8'hA6, 1'b0};

        rstb = 1'b0; req = 2'b00; req_wr_rdn = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checkOutput("rst_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("rst_done", {30'd0, done}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_m_ena", {31'd0, m_ena}, 32'd0);
        checkOutput("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
        rstb = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
        checkOutput("hold_rdata", {24'd0, rsp_rdata}, 32'hA6);

        // Both requesters held: strict alternation starting at 0, three cycles apart.
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        ack_delay = 0; bank_err = 1'b0;
        setRequester(0, 1'b0, 8'h03, 8'h00);
        setRequester(1, 1'b0, 8'h07, 8'h00);
        pushExp(2'b01, 8'hA5, 1'b0); pushExp(2'b10, 8'hA1, 1'b0);
        pushExp(2'b01, 8'hA5, 1'b0); pushExp(2'b10, 8'hA1, 1'b0);
        req = 2'b11;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done == 2'b00 && n < 16);
            checkOutput("rr_order", {30'd0, done}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) checkOutput("rr_spacing", cyc - last, 3);
            last = cyc;
        end
        req = 2'b00;
        @(negedge clk);
        checkOutput("rr_idle", {31'd0, busy}, 32'd0);

        // Bank never acks.
        setRequester(0, 1'b1, 8'h40, 8'h99);
        ack_delay = -1;
`ifdef REG_BANK_ARB_TIMEOUT_EN
        pushExp(2'b01, 8'h00, 1'b1);
        req = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 2'b00 && n < 40);
        checkOutput("timeout_latency", n, 17);
        req = 2'b00;
        @(negedge clk);
        checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
        req = 2'b01;
        repeat (5) @(negedge clk);
`else
        req = 2'b01;
        repeat (30) @(negedge clk);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);
        checkOutput("stall_m_ena", {31'd0, m_ena}, 32'd1);
        checkOutput("stall_gnt", {30'd0, gnt}, 32'd1);
`endif
        // Reset mid-ACCESS abandons the transaction silently.
        checkOutput("pre_rst_ena", {31'd0, m_ena}, 32'd1);
        rstb = 1'b0;
        req  = 2'b00;
        @(negedge clk);
        checkOutput("abort_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("abort_m_ena", {31'd0, m_ena}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {30'd0, done}, 32'd0);
        rstb = 1'b1;
        ack_delay = 0;
        setRequester(0, 1'b0, 8'h03, 8'h00);
        setRequester(1, 1'b0, 8'h07, 8'h00);
        pushExp(2'b01, 8'hA5, 1'b0);
        req = 2'b11;
        @(negedge clk);
        checkOutput("post_rst_gnt", {30'd0, gnt}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 2'b00 && n < 16);
        checkOutput("post_rst_done", {30'd0, done}, 32'd1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
